// File: rtl/fft_butterfly_pipe.sv
// Pipelined radix-2 butterfly: A' = A + B*W, B' = A - B*W (W conjugated for IFFT), optional /2.
// Register ranks: operands, partial products, complex product, rounded/scaled/saturated output.
module fft_butterfly_pipe #(
  parameter int DATA_WIDTH    = 24,
  parameter int TWIDDLE_WIDTH = 24
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [2*DATA_WIDTH-1:0]    i_data_a,
  input  logic [2*DATA_WIDTH-1:0]    i_data_b,
  input  logic [2*TWIDDLE_WIDTH-1:0] i_twiddle,
  input  logic                       i_inverse,
  input  logic                       i_scale,
  input  logic                       i_clear_ovf,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [2*DATA_WIDTH-1:0]    o_data_a_out,
  output logic [2*DATA_WIDTH-1:0]    o_data_b_out,
  output logic                       o_sat,
  output logic                       o_overflow
);

  localparam int DW = DATA_WIDTH;
  localparam int TW = TWIDDLE_WIDTH;
  localparam int MW = DW + TW;
  localparam int PW = DW + TW + 1;
  // Rounded product keeps one bit beyond DW+1 so the (-1-1j)*(-1-1j) corner cannot wrap either.
  localparam int RW = DW + 2;

  localparam logic signed [PW-1:0] RND     = {{(PW-TW+1){1'b0}}, 1'b1, {(TW-2){1'b0}}};
  localparam logic signed [RW-1:0] ONE     = {{(RW-1){1'b0}}, 1'b1};
  localparam logic signed [RW-1:0] SAT_MAX = {{(RW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN = {{(RW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic                 en;
  logic                 v1_q, v2_q, v3_q, vOut_q;
  logic [2*DW-1:0]      a1_q, b1_q, a2_q, a3_q;
  logic [2*TW-1:0]      w1_q;
  logic                 inv1_q, inv2_q;
  logic                 scale1_q, scale2_q, scale3_q;
  logic signed [MW-1:0] ppRR_q, ppII_q, ppRI_q, ppIR_q;
  logic signed [MW-1:0] ppRR_d, ppII_d, ppRI_d, ppIR_d;
  logic signed [PW-1:0] prodRe_q, prodIm_q;
  logic signed [PW-1:0] prodRe_d, prodIm_d;
  logic [2*DW-1:0]      outA_q, outB_q, outA_d, outB_d;
  logic                 sat_q, sat_d, ovf_q, ovf_d;

  logic signed [DW-1:0] bRe, bIm, aRe, aIm;
  logic signed [TW-1:0] wRe, wIm;
  logic signed [RW-1:0] pRe, pIm, aReX, aImX;
  logic [DW:0]          cAr, cAi, cBr, cBi;

  assign en           = !vOut_q || i_ready;
  assign o_ready      = en;
  assign o_valid      = vOut_q;
  assign o_data_a_out = outA_q;
  assign o_data_b_out = outB_q;
  assign o_sat        = sat_q;
  assign o_overflow   = ovf_q;

  assign bRe = b1_q[2*DW-1:DW];
  assign bIm = b1_q[DW-1:0];
  assign wRe = w1_q[2*TW-1:TW];
  assign wIm = w1_q[TW-1:0];
  assign aRe = a3_q[2*DW-1:DW];
  assign aIm = a3_q[DW-1:0];

  // Optional half-up halving, then clamp to the DW range; returns {saturated, value}.
  function automatic logic [DW:0] shapeComp(input logic signed [RW-1:0] x, input logic scale);
    logic signed [RW-1:0] y;
    y = scale ? ((x + ONE) >>> 1) : x;
    if (y > SAT_MAX) return {1'b1, SAT_MAX[DW-1:0]};
    if (y < SAT_MIN) return {1'b1, SAT_MIN[DW-1:0]};
    return {1'b0, y[DW-1:0]};
  endfunction

  always_comb begin
    ppRR_d = MW'(bRe) * MW'(wRe);
    ppII_d = MW'(bIm) * MW'(wIm);
    ppRI_d = MW'(bRe) * MW'(wIm);
    ppIR_d = MW'(bIm) * MW'(wRe);

    // Conjugating W flips the sign of every wIm term instead of negating wIm itself.
    prodRe_d = inv2_q ? PW'(ppRR_q) + PW'(ppII_q) : PW'(ppRR_q) - PW'(ppII_q);
    prodIm_d = inv2_q ? PW'(ppIR_q) - PW'(ppRI_q) : PW'(ppRI_q) + PW'(ppIR_q);

    pRe  = RW'((prodRe_q + RND) >>> (TW - 1));
    pIm  = RW'((prodIm_q + RND) >>> (TW - 1));
    aReX = RW'(aRe);
    aImX = RW'(aIm);

    cAr = shapeComp(aReX + pRe, scale3_q);
    cAi = shapeComp(aImX + pIm, scale3_q);
    cBr = shapeComp(aReX - pRe, scale3_q);
    cBi = shapeComp(aImX - pIm, scale3_q);

    outA_d = {cAr[DW-1:0], cAi[DW-1:0]};
    outB_d = {cBr[DW-1:0], cBi[DW-1:0]};
    sat_d  = v3_q && (cAr[DW] || cAi[DW] || cBr[DW] || cBi[DW]);

    // A saturated word landing in the output register wins over a same-edge clear.
    ovf_d = ovf_q;
    if (en && sat_d) begin
      ovf_d = 1'b1;
    end else if (i_clear_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      vOut_q   <= 1'b0;
      a1_q     <= '0;
      b1_q     <= '0;
      w1_q     <= '0;
      inv1_q   <= 1'b0;
      scale1_q <= 1'b0;
      a2_q     <= '0;
      inv2_q   <= 1'b0;
      scale2_q <= 1'b0;
      ppRR_q   <= '0;
      ppII_q   <= '0;
      ppRI_q   <= '0;
      ppIR_q   <= '0;
      a3_q     <= '0;
      scale3_q <= 1'b0;
      prodRe_q <= '0;
      prodIm_q <= '0;
      outA_q   <= '0;
      outB_q   <= '0;
      sat_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      if (en) begin
        v1_q     <= i_valid;
        a1_q     <= i_data_a;
        b1_q     <= i_data_b;
        w1_q     <= i_twiddle;
        inv1_q   <= i_inverse;
        scale1_q <= i_scale;

        v2_q     <= v1_q;
        a2_q     <= a1_q;
        inv2_q   <= inv1_q;
        scale2_q <= scale1_q;
        ppRR_q   <= ppRR_d;
        ppII_q   <= ppII_d;
        ppRI_q   <= ppRI_d;
        ppIR_q   <= ppIR_d;

        v3_q     <= v2_q;
        a3_q     <= a2_q;
        scale3_q <= scale2_q;
        prodRe_q <= prodRe_d;
        prodIm_q <= prodIm_d;

        vOut_q   <= v3_q;
        outA_q   <= outA_d;
        outB_q   <= outB_d;
        sat_q    <= sat_d;
      end
    end
  end

endmodule

// File: tb/tb_fft_butterfly_pipe.sv
// Directed bench for fft_butterfly_pipe: hand-computed butterfly results, latency,
// rounding, saturation/overflow, backpressure and mid-flight reset.
module tb_fft_butterfly_pipe;

  localparam int DW = 24;
  localparam int TW = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_valid;
  logic          o_ready;
  logic [2*DW-1:0] i_data_a;
  logic [2*DW-1:0] i_data_b;
  logic [2*TW-1:0] i_twiddle;
  logic          i_inverse;
  logic          i_scale;
  logic          i_clear_ovf;
  logic          o_valid;
  logic          i_ready;
  logic [2*DW-1:0] o_data_a_out;
  logic [2*DW-1:0] o_data_b_out;
  logic          o_sat;
  logic          o_overflow;

  int nChecks = 0;
  int nPass   = 0;
  int nFail   = 0;

  always #5 clk = ~clk;

  fft_butterfly_pipe #(
    .DATA_WIDTH   (DW),
    .TWIDDLE_WIDTH(TW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_data_a    (i_data_a),
    .i_data_b    (i_data_b),
    .i_twiddle   (i_twiddle),
    .i_inverse   (i_inverse),
    .i_scale     (i_scale),
    .i_clear_ovf (i_clear_ovf),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data_a_out(o_data_a_out),
    .o_data_b_out(o_data_b_out),
    .o_sat       (o_sat),
    .o_overflow  (o_overflow)
  );

  // Packs a {re, im} pair into the low 2*DW bits of a 64-bit word.
  function automatic logic [63:0] cplx(input int re, input int im);
    logic [DW-1:0] r;
    logic [DW-1:0] m;
    r = re[DW-1:0];
    m = im[DW-1:0];
    return {{(64-2*DW){1'b0}}, r, m};
  endfunction

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nChecks++;
    assert (observed === expected) nPass++;
    else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    nChecks++;
    assert (observed === expected) nPass++;
    else begin
      nFail++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Presents one operand set and returns #1 after the edge that accepted it.
  task automatic applyStimulus(input int aRe, input int aIm, input int bRe, input int bIm,
                               input int wRe, input int wIm, input logic inv, input logic sc,
                               input logic hold);
    logic [63:0] tmp;
    int t;
    @(negedge clk);
    tmp = cplx(aRe, aIm);
    i_data_a = tmp[2*DW-1:0];
    tmp = cplx(bRe, bIm);
    i_data_b = tmp[2*DW-1:0];
    tmp = cplx(wRe, wIm);
    i_twiddle = tmp[2*TW-1:0];
    i_inverse = inv;
    i_scale   = sc;
    i_valid   = 1'b1;
    t = 0;
    while (o_ready !== 1'b1 && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 50) checkBit("accept_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    if (!hold) i_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] expA, input logic [63:0] expB,
                             input logic expSat);
    int t;
    t = 0;
    while (o_valid !== 1'b1 && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    checkBit({tag, "_valid"}, o_valid, 1'b1);
    check({tag, "_a"}, {16'h0, o_data_a_out}, expA);
    check({tag, "_b"}, {16'h0, o_data_b_out}, expB);
    checkBit({tag, "_sat"}, o_sat, expSat);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset       = 1'b0;
    i_valid     = 1'b0;
    i_data_a    = '0;
    i_data_b    = '0;
    i_twiddle   = '0;
    i_inverse   = 1'b0;
    i_scale     = 1'b0;
    i_clear_ovf = 1'b0;
    i_ready     = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkBit("rst_valid", o_valid, 1'b0);
    check("rst_a", {16'h0, o_data_a_out}, 64'h0);
    check("rst_b", {16'h0, o_data_b_out}, 64'h0);
    checkBit("rst_sat", o_sat, 1'b0);
    checkBit("rst_ovf", o_overflow, 1'b0);
    reset = 1'b1;
    checkBit("rst_ready", o_ready, 1'b1);

    // W = -j, forward, scaled, with three-edge latency
    applyStimulus(100, 50, 20, -30, 0, -8388608, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      checkBit($sformatf("lat_edge%0d", k), o_valid, (k == 3));
    end
    checkOutput("fwd_mj", cplx(35, 15), cplx(65, 35), 1'b0);

    // Same operands, inverse
    applyStimulus(100, 50, 20, -30, 0, -8388608, 1'b1, 1'b1, 1'b0);
    checkOutput("inv_mj", cplx(65, 35), cplx(35, 15), 1'b0);

    // Half-up rounding of the scaled sum
    applyStimulus(3, -3, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    checkOutput("half_up", cplx(2, -1), cplx(2, -1), 1'b0);

    // Product rounding with W = 0.5: 1.5 -> 2, -1.5 -> -1
    applyStimulus(0, 0, 3, 0, 4194304, 0, 1'b0, 1'b0, 1'b0);
    checkOutput("prod_rnd_pos", cplx(2, 0), cplx(-2, 0), 1'b0);
    applyStimulus(0, 0, -3, 0, 4194304, 0, 1'b0, 1'b0, 1'b0);
    checkOutput("prod_rnd_neg", cplx(-1, 0), cplx(1, 0), 1'b0);

    // -1 x -1 product must not wrap
    applyStimulus(0, 0, -8388608, 0, -8388608, 0, 1'b0, 1'b1, 1'b0);
    checkOutput("m1_m1", cplx(4194304, 0), cplx(-4194304, 0), 1'b0);

    // Positive saturation sets the sticky flag
    applyStimulus(8388607, 0, 8388607, 0, -8388608, 0, 1'b0, 1'b0, 1'b0);
    checkOutput("sat_pos", cplx(0, 0), cplx(8388607, 0), 1'b1);
    checkBit("ovf_set", o_overflow, 1'b1);

    applyStimulus(3, -3, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    checkOutput("after_sat", cplx(2, -1), cplx(2, -1), 1'b0);
    checkBit("ovf_sticky", o_overflow, 1'b1);

    @(negedge clk);
    i_clear_ovf = 1'b1;
    @(posedge clk);
    #1;
    i_clear_ovf = 1'b0;
    checkBit("ovf_cleared", o_overflow, 1'b0);

    // Set beats a simultaneous clear
    @(negedge clk);
    i_clear_ovf = 1'b1;
    applyStimulus(8388607, 0, 8388607, 0, -8388608, 0, 1'b0, 1'b0, 1'b0);
    checkOutput("sat_prio", cplx(0, 0), cplx(8388607, 0), 1'b1);
    checkBit("ovf_set_prio", o_overflow, 1'b1);
    @(posedge clk);
    #1;
    checkBit("ovf_clear_held", o_overflow, 1'b0);
    i_clear_ovf = 1'b0;

    // Negative saturation
    applyStimulus(-8388608, 0, 8388607, 0, -8388608, 0, 1'b0, 1'b0, 1'b0);
    checkOutput("sat_neg", cplx(-8388608, 0), cplx(-1, 0), 1'b1);
    checkBit("ovf_neg", o_overflow, 1'b1);
    @(posedge clk);
    #1;
    checkBit("drained", o_valid, 1'b0);

    // Four back-to-back with W = -1, downstream stalled for five cycles
    i_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(10 * k, k, k, 2, -8388608, 0, 1'b0, 1'b0, 1'b1);
    end
    i_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checkBit($sformatf("stall%0d_ready", k), o_ready, 1'b0);
      checkBit($sformatf("stall%0d_valid", k), o_valid, 1'b1);
      check($sformatf("stall%0d_a", k), {16'h0, o_data_a_out}, cplx(9, -1));
      check($sformatf("stall%0d_b", k), {16'h0, o_data_b_out}, cplx(11, 3));
      @(posedge clk);
      #1;
    end
    i_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checkBit($sformatf("burst%0d_valid", k), o_valid, 1'b1);
      check($sformatf("burst%0d_a", k), {16'h0, o_data_a_out}, cplx(9 * k, k - 2));
      check($sformatf("burst%0d_b", k), {16'h0, o_data_b_out}, cplx(11 * k, k + 2));
      @(posedge clk);
      #1;
    end
    checkBit("burst_end", o_valid, 1'b0);

    // Reset with three operands in flight
    for (int k = 0; k < 3; k++) begin
      applyStimulus(100, 50, 20, -30, 0, -8388608, 1'b0, 1'b1, 1'b1);
    end
    i_valid = 1'b0;
    reset   = 1'b0;
    @(posedge clk);
    #1;
    checkBit("flight_rst_valid", o_valid, 1'b0);
    check("flight_rst_a", {16'h0, o_data_a_out}, 64'h0);
    check("flight_rst_b", {16'h0, o_data_b_out}, 64'h0);
    checkBit("flight_rst_ovf", o_overflow, 1'b0);
    reset = 1'b1;
    checkBit("flight_rst_ready", o_ready, 1'b1);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      checkBit($sformatf("no_stale%0d", k), o_valid, 1'b0);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/fft_butterfly_pipe.md
FFT_BUTTERFLY_PIPE -- requirements
Module: fft_butterfly_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, meaning signed width of each real/imag data component.
REQ-002 SHALL have parameter TWIDDLE_WIDTH, default 24, meaning signed Q1.(TWIDDLE_WIDTH-1) width of each twiddle component.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port i_valid  input  1  input operands valid.
REQ-006 SHALL have port o_ready  output  1  block can accept an input this cycle.
REQ-007 SHALL have port i_data_a  input  2*DATA_WIDTH  operand A, packed {re, im}, signed.
REQ-008 SHALL have port i_data_b  input  2*DATA_WIDTH  operand B, packed {re, im}, signed.
REQ-009 SHALL have port i_twiddle  input  2*TWIDDLE_WIDTH  twiddle W, packed {re, im}, signed.
REQ-010 SHALL have port i_inverse  input  1  1 = use conj(W) (IFFT); sampled with operands.
REQ-011 SHALL have port i_scale  input  1  1 = divide outputs by 2; sampled with operands.
REQ-012 SHALL have port i_clear_ovf  input  1  clears o_overflow.
REQ-013 SHALL have port o_valid  output  1  outputs valid.
REQ-014 SHALL have port i_ready  input  1  downstream accepts output.
REQ-015 SHALL have port o_data_a_out  output  2*DATA_WIDTH  A' packed {re, im}.
REQ-016 SHALL have port o_data_b_out  output  2*DATA_WIDTH  B' packed {re, im}.
REQ-017 SHALL have port o_sat  output  1  current output word contains at least one saturated component.
REQ-018 SHALL have port o_overflow  output  1  sticky saturation flag.

Function
REQ-019 SHALL compute P = B*W' (W' = conj(W) if i_inverse else W), A' = A + P, B' = A - P, then /2 if i_scale.
REQ-020 SHALL be a 3-stage pipeline: S1 register operands/mode bits, S2 full-precision products, S3 round/add/scale/saturate into output registers.
REQ-021 SHALL compute products at DATA_WIDTH+TWIDDLE_WIDTH+1 bits, then round half-up: add 2^(TWIDDLE_WIDTH-2), arithmetic shift right TWIDDLE_WIDTH-1, keep DATA_WIDTH+1 bits (no wrap for -1 x -1).
REQ-022 SHALL form sums/differences at DATA_WIDTH+2 bits; when i_scale=1 apply (x+1)>>>1 (round half-up); when 0 no shift.
REQ-023 SHALL saturate each component to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; never wrap.
REQ-024 SHALL advance all stages together on enable = !o_valid || i_ready; o_ready SHALL equal enable.
REQ-025 SHALL accept an input on an edge where i_valid && o_ready; with no stall, o_valid SHALL be 1 after the 3rd subsequent edge (edge N accepted -> valid after edge N+3).
REQ-026 SHALL sustain one result per cycle with i_ready held 1; valid bits SHALL propagate with data (bubbles preserved).
REQ-027 SHALL hold o_data_*, o_sat, o_valid stable while o_valid && !i_ready; no data lost or duplicated, order preserved.
REQ-028 SHALL set o_overflow on the edge an output word with o_sat=1 is registered; i_clear_ovf SHALL clear it, set taking priority when both occur on the same edge.

Reset
REQ-029 SHALL, on any edge with reset=0, clear all stage valid bits, o_valid, o_sat, o_overflow and zero o_data_a_out/o_data_b_out, discarding in-flight operands.
REQ-030 SHALL drive o_ready=1 on the first cycle after reset release.

Verification
REQ-031 W=-j (re 0, im -2^23), A=100+50j, B=20-30j, scale=1, inverse=0 -> A'=35+15j, B'=65+35j exact, o_valid after 3rd edge.
REQ-032 Same operands with inverse=1 -> A'=65+35j, B'=35+15j.
REQ-033 W=0, scale=1, A=3+(-3)j, B=0 -> A'=B'=2+(-1)j (half-up rounding).
REQ-034 W=-1 (re -2^23, im 0), scale=0, A=B=8388607+0j -> A'=0+0j, B'=8388607+0j saturated, o_sat=1, o_overflow=1 until i_clear_ovf pulse.
REQ-035 Four back-to-back inputs, i_ready low 5 cycles once o_valid rises -> o_ready low, outputs frozen, then all four emerge in order with no gaps after i_ready returns 1.
REQ-036 Reset asserted with 3 operands in flight -> next edge o_valid=0, outputs 0, o_overflow=0; no stale output after release.
